// File: rtl/com_sw_to_fw_pkg.sv
// Shared field layout, op-codes, FSM states and status-bit positions for the
// software-to-firmware command sequencer.
package com_sw_to_fw_pkg;

    localparam int DEV_ID_W   = 4;
    localparam int OP_W       = 4;
    localparam int BODY_W     = 24;
    localparam int DEV_ID_MSB = 31;
    localparam int DEV_ID_LSB = 28;
    localparam int OP_MSB     = 27;
    localparam int OP_LSB     = 24;
    localparam int BODY_MSB   = 23;
    localparam int BODY_LSB   = 0;
    localparam int FW_STAT_W  = 8;
    localparam int STROBE_W   = 16;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP           = 4'h0,
        OP_RST_FW         = 4'h1,
        OP_W_CFG_STATIC_0 = 4'h2,
        OP_R_CFG_STATIC_0 = 4'h3,
        OP_W_CFG_DYN_0    = 4'h4,
        OP_R_CFG_DYN_0    = 4'h5,
        OP_W_DATA         = 4'h6,
        OP_R_DATA         = 4'h7,
        OP_START          = 4'h8,
        OP_STOP           = 4'h9,
        OP_ARM            = 4'hA,
        OP_R_STATUS       = 4'hB,
        OP_STATUS_CLEAR   = 4'hC,
        OP_USER           = 4'hD
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE
    } state_e;

    // Sticky error flags live in the low nibble of the status readback word.
    localparam int STAT_BAD_DEV = 0;
    localparam int STAT_BAD_OP  = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_OVERRUN = 3;

    function automatic logic op_is_forwardable(input logic [OP_W-1:0] op);
        return (op != OP_NOOP) && (op <= OP_USER);
    endfunction

endpackage

// File: rtl/com_dev_id_decode.sv
// Maps the 4-bit device-ID field onto a firmware index and one-hot select,
// flagging IDs that address no attached firmware block.
module com_dev_id_decode
    import com_sw_to_fw_pkg::*;
#(
    parameter int NUM_FW        = 4,
    parameter int DEV_ID_ONEHOT = 1
) (
    input  logic [DEV_ID_W-1:0] dev_id_i,
    output logic                valid_o,
    output logic [DEV_ID_W-1:0] index_o,
    output logic [NUM_FW-1:0]   onehot_o
);

    logic                id_ok;
    logic [DEV_ID_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        id_ok    = 1'b0;
        idx      = '0;
        valid_o  = 1'b0;
        index_o  = '0;
        onehot_o = '0;

        if (DEV_ID_ONEHOT != 0) begin
            case (dev_id_i)
                4'b0001: begin id_ok = 1'b1; idx = 4'd0; end
                4'b0010: begin id_ok = 1'b1; idx = 4'd1; end
                4'b0100: begin id_ok = 1'b1; idx = 4'd2; end
                4'b1000: begin id_ok = 1'b1; idx = 4'd3; end
                default: begin id_ok = 1'b0; idx = 4'd0; end
            endcase
        end else if (dev_id_i != '0) begin
            id_ok = 1'b1;
            idx   = dev_id_i - 4'd1;
        end

        if (id_ok && (32'(idx) < NUM_FW)) begin
            valid_o = 1'b1;
            index_o = idx;
            for (int k = 0; k < NUM_FW; k++) begin
                onehot_o[k] = (32'(idx) == k);
            end
        end
    end

endmodule

// File: rtl/com_sw_to_fw_seq.sv
// Clocked command sequencer: accepts a software command word, strobes one
// firmware block, waits for its acknowledge (bounded) and publishes readback.
module com_sw_to_fw_seq
    import com_sw_to_fw_pkg::*;
#(
    parameter int NUM_FW        = 4,
    parameter int DEV_ID_ONEHOT = 1,
    parameter int TIMEOUT_CYC   = 1024,
    parameter int TO_CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              sw_write32_0,
    input  logic                     sw_write_valid,
    output logic [31:0]              sw_read32_0,
    output logic [31:0]              sw_read32_1,
    output logic                     sw_busy,
    output logic [NUM_FW-1:0]        fw_dev_id_enable,
    output logic [STROBE_W-1:0]      fw_op_strobe,
    output logic [BODY_W-1:0]        sw_write24_0,
    input  logic [NUM_FW-1:0]        fw_ack,
    input  logic [NUM_FW*32-1:0]     fw_read_data32,
    input  logic [NUM_FW*32-1:0]     fw_read_status32
);

    state_e                state_q, state_d;
    logic [DEV_ID_W-1:0]   dev_id_q, dev_id_d;
    logic [OP_W-1:0]       op_q, op_d;
    logic [BODY_W-1:0]     body_q, body_d;
    logic [DEV_ID_W-1:0]   idx_q, idx_d;
    logic [NUM_FW-1:0]     en_q, en_d;
    logic [STROBE_W-1:0]   strobe_q, strobe_d;
    logic                  busy_q, busy_d;
    logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [FW_STAT_W-1:0]  fw_stat_q, fw_stat_d;
    logic [7:0]            cmd_cnt_q, cmd_cnt_d;
    logic [DEV_ID_W-1:0]   last_dev_q, last_dev_d;
    logic [OP_W-1:0]       last_op_q, last_op_d;
    logic [3:0]            flags_q, flags_d;

    logic                  dec_valid;
    logic [DEV_ID_W-1:0]   dec_index;
    logic [NUM_FW-1:0]     dec_onehot;

    logic                  sel_ack;
    logic [31:0]           sel_data;
    logic [31:0]           sel_status;

    com_dev_id_decode #(
        .NUM_FW        (NUM_FW),
        .DEV_ID_ONEHOT (DEV_ID_ONEHOT)
    ) u_dev_id_decode (
        .dev_id_i (dev_id_q),
        .valid_o  (dec_valid),
        .index_o  (dec_index),
        .onehot_o (dec_onehot)
    );

    // Only the addressed block's ack/data/status are visible to the FSM.
    always_comb begin
        sel_ack    = 1'b0;
        sel_data   = '0;
        sel_status = '0;
        for (int k = 0; k < NUM_FW; k++) begin
            if (32'(idx_q) == k) begin
                sel_ack    = fw_ack[k];
                sel_data   = fw_read_data32[k*32 +: 32];
                sel_status = fw_read_status32[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        dev_id_d   = dev_id_q;
        op_d       = op_q;
        body_d     = body_q;
        idx_d      = idx_q;
        en_d       = en_q;
        strobe_d   = '0;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        fw_stat_d  = fw_stat_q;
        cmd_cnt_d  = cmd_cnt_q;
        last_dev_d = last_dev_q;
        last_op_d  = last_op_q;
        flags_d    = flags_q;

        case (state_q)
            S_IDLE: begin
                if (sw_write_valid) begin
                    dev_id_d = sw_write32_0[DEV_ID_MSB:DEV_ID_LSB];
                    op_d     = sw_write32_0[OP_MSB:OP_LSB];
                    body_d   = sw_write32_0[BODY_MSB:BODY_LSB];
                    busy_d   = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                idx_d = dec_index;
                if (!dec_valid) begin
                    flags_d[STAT_BAD_DEV] = 1'b1;
                    state_d               = S_DONE;
                end else if (op_q == OP_NOOP) begin
                    state_d = S_DONE;
                end else if (!op_is_forwardable(op_q)) begin
                    flags_d[STAT_BAD_OP] = 1'b1;
                    state_d              = S_DONE;
                end else begin
                    en_d           = dec_onehot;
                    strobe_d[op_q] = 1'b1;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                cnt_d = cnt_q + TO_CNT_W'(1);
                if (sel_ack) begin
                    rd_data_d = sel_data;
                    fw_stat_d = sel_status[FW_STAT_W-1:0];
                    state_d   = S_DONE;
                end else if (cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1)) begin
                    flags_d[STAT_TIMEOUT] = 1'b1;
                    state_d               = S_DONE;
                end
            end
            S_DONE: begin
                cmd_cnt_d  = cmd_cnt_q + 8'd1;
                last_dev_d = idx_q;
                last_op_d  = op_q;
                en_d       = '0;
                busy_d     = 1'b0;
                // The clear only takes effect for a command that was actually forwarded.
                if ((op_q == OP_STATUS_CLEAR) && dec_valid) begin
                    flags_d = '0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A write arriving while busy is dropped; a concurrent clear loses to it.
        if (sw_write_valid && (state_q != S_IDLE)) begin
            flags_d[STAT_OVERRUN] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dev_id_q   <= '0;
            op_q       <= '0;
            body_q     <= '0;
            idx_q      <= '0;
            en_q       <= '0;
            strobe_q   <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            fw_stat_q  <= '0;
            cmd_cnt_q  <= '0;
            last_dev_q <= '0;
            last_op_q  <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            dev_id_q   <= dev_id_d;
            op_q       <= op_d;
            body_q     <= body_d;
            idx_q      <= idx_d;
            en_q       <= en_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            fw_stat_q  <= fw_stat_d;
            cmd_cnt_q  <= cmd_cnt_d;
            last_dev_q <= last_dev_d;
            last_op_q  <= last_op_d;
            flags_q    <= flags_d;
        end
    end

    assign sw_read32_0      = rd_data_q;
    assign sw_read32_1      = {cmd_cnt_q, last_dev_q, last_op_q, fw_stat_q, 4'b0000, flags_q};
    assign sw_busy          = busy_q;
    assign fw_dev_id_enable = en_q;
    assign fw_op_strobe     = strobe_q;
    assign sw_write24_0     = body_q;

endmodule

// File: tb/tb_com_sw_to_fw_seq.sv
// Directed bench for com_sw_to_fw_seq: four one-hot firmware blocks, a
// 16-cycle timeout, hand-computed readback words.
module tb_com_sw_to_fw_seq;

    localparam int NUM_FW      = 4;
    localparam int TIMEOUT_CYC = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:0]          sw_write32_0;
    logic                 sw_write_valid;
    logic [31:0]          sw_read32_0;
    logic [31:0]          sw_read32_1;
    logic                 sw_busy;
    logic [NUM_FW-1:0]    fw_dev_id_enable;
    logic [15:0]          fw_op_strobe;
    logic [23:0]          sw_write24_0;
    logic [NUM_FW-1:0]    fw_ack;
    logic [NUM_FW*32-1:0] fw_read_data32;
    logic [NUM_FW*32-1:0] fw_read_status32;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int strobe_base;

    com_sw_to_fw_seq #(
        .NUM_FW        (NUM_FW),
        .DEV_ID_ONEHOT (1),
        .TIMEOUT_CYC   (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sw_write32_0     (sw_write32_0),
        .sw_write_valid   (sw_write_valid),
        .sw_read32_0      (sw_read32_0),
        .sw_read32_1      (sw_read32_1),
        .sw_busy          (sw_busy),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_op_strobe     (fw_op_strobe),
        .sw_write24_0     (sw_write24_0),
        .fw_ack           (fw_ack),
        .fw_read_data32   (fw_read_data32),
        .fw_read_status32 (fw_read_status32)
    );

    always #5 clk = ~clk;

    // Counts clock cycles in which any op strobe was high.
    always @(posedge clk) begin
        if (fw_op_strobe != 16'h0) n_strobe++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns one falling edge later (DECODE cycle).
    task automatic pulse_write(input logic [31:0] word);
        sw_write32_0   = word;
        sw_write_valid = 1'b1;
        @(negedge clk);
        sw_write_valid = 1'b0;
    endtask

    task automatic pulse_ack(input int k);
        fw_ack[k] = 1'b1;
        @(negedge clk);
        fw_ack = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        sw_write32_0     = '0;
        sw_write_valid   = 1'b0;
        fw_ack           = '0;
        fw_read_data32   = {32'h4444_0004, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
        fw_read_status32 = {32'h0000_0044, 32'h0000_0022, 32'h0000_0011, 32'h0000_00A5};
        step(3);
        check("reset_rd0", sw_read32_0, 32'h0);
        check("reset_rd1", sw_read32_1, 32'h0);
        check("reset_busy", {31'h0, sw_busy}, 32'h0);
        check("reset_strobe", {16'h0, fw_op_strobe}, 32'h0);
        reset = 1'b0;
        step(1);

        // Dev 1, R_CFG_STATIC_0, fw0 acks three cycles after the strobe.
        strobe_base = n_strobe;
        pulse_write(32'h1300_00AB);
        check("t1_busy_decode", {31'h0, sw_busy}, 32'h1);
        check("t1_no_early_strobe", {16'h0, fw_op_strobe}, 32'h0);
        step(1);
        check("t1_strobe", {16'h0, fw_op_strobe}, 32'h0000_0008);
        check("t1_enable", {28'h0, fw_dev_id_enable}, 32'h1);
        check("t1_body", {8'h0, sw_write24_0}, 32'h0000_00AB);
        step(1);
        check("t1_strobe_drop", {16'h0, fw_op_strobe}, 32'h0);
        step(1);
        pulse_ack(0);
        check("t1_rd0", sw_read32_0, 32'hDEAD_BEEF);
        step(1);
        check("t1_busy_done", {31'h0, sw_busy}, 32'h0);
        check("t1_enable_drop", {28'h0, fw_dev_id_enable}, 32'h0);
        check("t1_rd1", sw_read32_1, 32'h0103_A500);
        check("t1_strobe_cycles", n_strobe - strobe_base, 1);

        // Dev-ID 3 is not one-hot: bad_dev, no strobe, read data kept.
        strobe_base = n_strobe;
        pulse_write(32'h3200_0000);
        step(2);
        check("t2_flags", {28'h0, sw_read32_1[3:0]}, 32'h1);
        check("t2_cmd_cnt", {24'h0, sw_read32_1[31:24]}, 32'd2);
        check("t2_rd0_kept", sw_read32_0, 32'hDEAD_BEEF);
        check("t2_no_strobe", n_strobe - strobe_base, 0);

        // STATUS_CLEAR to fw0: strobe bit 12, flags cleared in DONE.
        pulse_write(32'h1C00_0000);
        step(1);
        check("t3_strobe", {16'h0, fw_op_strobe}, 32'h0000_1000);
        step(1);
        pulse_ack(0);
        step(1);
        check("t3_rd1", sw_read32_1, 32'h030C_A500);

        // fw1 never acks; a stray fw0 ack is ignored; timeout decided in the
        // 16th cycle after ISSUE and visible the cycle after.
        pulse_write(32'h2D00_0001);
        step(1);
        check("t4_strobe", {16'h0, fw_op_strobe}, 32'h0000_2000);
        check("t4_enable", {28'h0, fw_dev_id_enable}, 32'h2);
        check("t4_body", {8'h0, sw_write24_0}, 32'h0000_0001);
        step(2);
        pulse_ack(0);
        step(13);
        check("t4_busy_before_to", {31'h0, sw_busy}, 32'h1);
        check("t4_no_early_to", {31'h0, sw_read32_1[2]}, 32'h0);
        step(1);
        check("t4_timeout", {31'h0, sw_read32_1[2]}, 32'h1);
        pulse_ack(1);
        check("t4_rd0_kept", sw_read32_0, 32'hDEAD_BEEF);
        check("t4_rd1", sw_read32_1, 32'h041D_A504);

        // Second write during WAIT_ACK is dropped with overrun.
        strobe_base = n_strobe;
        pulse_write(32'h4500_0010);
        step(1);
        check("t5_strobe", {16'h0, fw_op_strobe}, 32'h0000_0020);
        check("t5_enable", {28'h0, fw_dev_id_enable}, 32'h4);
        step(1);
        pulse_write(32'h2600_0000);
        pulse_ack(2);
        step(1);
        check("t5_rd0", sw_read32_0, 32'h2222_0002);
        check("t5_rd1", sw_read32_1, 32'h0525_220C);
        step(4);
        check("t5_second_dropped", n_strobe - strobe_base, 1);
        check("t5_idle", {31'h0, sw_busy}, 32'h0);

        // Op-code 15 is rejected; NOOP only bumps the counter.
        strobe_base = n_strobe;
        pulse_write(32'h1F00_0000);
        step(2);
        check("t6_bad_op", {28'h0, sw_read32_1[3:0]}, 32'hE);
        pulse_write(32'h1000_0000);
        step(2);
        check("t6_noop_rd1", sw_read32_1, 32'h0700_220E);
        check("t6_no_strobe", n_strobe - strobe_base, 0);

        // Reset while fw3 is being waited on.
        pulse_write(32'h8700_0000);
        step(1);
        check("t7_enable", {28'h0, fw_dev_id_enable}, 32'h8);
        step(2);
        reset = 1'b1;
        #1;
        check("t7_rst_rd0", sw_read32_0, 32'h0);
        check("t7_rst_rd1", sw_read32_1, 32'h0);
        check("t7_rst_busy", {31'h0, sw_busy}, 32'h0);
        check("t7_rst_enable", {28'h0, fw_dev_id_enable}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        pulse_write(32'h1300_0000);
        step(1);
        check("t7_after_strobe", {16'h0, fw_op_strobe}, 32'h0000_0008);
        step(1);
        pulse_ack(0);
        step(1);
        check("t7_after_rd0", sw_read32_0, 32'hDEAD_BEEF);
        check("t7_after_rd1", sw_read32_1, 32'h0103_A500);

        // 255 more NOOPs after the first command: counter reaches 255 then wraps.
        for (int i = 0; i < 254; i++) begin
            pulse_write(32'h1000_0000);
            step(2);
        end
        check("t8_cnt_255", {24'h0, sw_read32_1[31:24]}, 32'd255);
        pulse_write(32'h1000_0000);
        step(2);
        check("t8_cnt_wrap", {24'h0, sw_read32_1[31:24]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
